// File: rtl/codec_config_sequencer.sv
// Codec configuration sequencer.
// Sole master of the I2C single-register write block. On start it walks an
// external {register, data} table in order; once the table has been written
// it serves runtime single-register writes from the host port. Every write is
// followed by an idle gap, and every wait for completion is bounded.
module codec_config_sequencer #(
   parameter int         NUM_REGS       = 10,
   parameter int         IDX_W          = 4,
   parameter logic [7:0] CODEC_ADDR     = 8'h34,
   parameter int         GAP_CYCLES     = 16,
   parameter int         TIMEOUT_CYCLES = 1000000
) (
   input  logic             sys_clk,
   input  logic             reset,
   input  logic             start,
   output logic [IDX_W-1:0] tbl_index,
   input  logic [7:0]       tbl_reg,
   input  logic [7:0]       tbl_data,
   input  logic             host_req,
   input  logic [7:0]       host_reg,
   input  logic [7:0]       host_data,
   output logic             host_ack,
   output logic [7:0]       wr_addr,
   output logic [7:0]       wr_register,
   output logic [7:0]       wr_data,
   output logic             wr_write,
   input  logic             wr_done,
   output logic             busy,
   output logic             init_done,
   output logic             timeout_err
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_ISSUE,
      S_WAIT_DONE,
      S_GAP
   } state_t;

   typedef enum logic {
      SRC_INIT,
      SRC_HOST
   } src_t;

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REGS - 1);
   localparam logic [15:0]      GAP_LAST = 16'(GAP_CYCLES);
   localparam logic [31:0]      TO_LAST  = 32'(TIMEOUT_CYCLES - 1);

   // Counters saturate instead of wrapping.
   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   function automatic logic [31:0] sat_inc32(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

   state_t           state_q, state_d;
   src_t             src_q, src_d;
   logic [IDX_W-1:0] tbl_index_q, tbl_index_d;
   logic [7:0]       wr_register_q, wr_register_d;
   logic [7:0]       wr_data_q, wr_data_d;
   logic             host_ack_q, host_ack_d;
   logic             init_done_q, init_done_d;
   logic             timeout_err_q, timeout_err_d;
   logic [15:0]      gap_cnt_q, gap_cnt_d;
   logic [31:0]      to_cnt_q, to_cnt_d;

   // State register and all held control/data values.
   always_ff @(posedge sys_clk) begin
      if (reset) begin
         state_q       <= S_IDLE;
         src_q         <= SRC_INIT;
         tbl_index_q   <= '0;
         wr_register_q <= '0;
         wr_data_q     <= '0;
         host_ack_q    <= 1'b0;
         init_done_q   <= 1'b0;
         timeout_err_q <= 1'b0;
         gap_cnt_q     <= '0;
         to_cnt_q      <= '0;
      end else begin
         state_q       <= state_d;
         src_q         <= src_d;
         tbl_index_q   <= tbl_index_d;
         wr_register_q <= wr_register_d;
         wr_data_q     <= wr_data_d;
         host_ack_q    <= host_ack_d;
         init_done_q   <= init_done_d;
         timeout_err_q <= timeout_err_d;
         gap_cnt_q     <= gap_cnt_d;
         to_cnt_q      <= to_cnt_d;
      end
   end

   // Next-state logic: table walk, host arbitration, gap and timeout handling.
   always_comb begin
      state_d       = state_q;
      src_d         = src_q;
      tbl_index_d   = tbl_index_q;
      wr_register_d = wr_register_q;
      wr_data_d     = wr_data_q;
      host_ack_d    = 1'b0;
      init_done_d   = init_done_q;
      timeout_err_d = timeout_err_q;
      gap_cnt_d     = gap_cnt_q;
      to_cnt_d      = to_cnt_q;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               src_d         = SRC_INIT;
               tbl_index_d   = '0;
               init_done_d   = 1'b0;
               timeout_err_d = 1'b0;
               state_d       = S_LOAD;
            end else if (host_req && init_done_q) begin
               src_d         = SRC_HOST;
               wr_register_d = host_reg;
               wr_data_d     = host_data;
               state_d       = S_ISSUE;
            end
         end

         // One cycle for the table's registered read to settle.
         S_LOAD: begin
            state_d = S_ISSUE;
         end

         S_ISSUE: begin
            if (src_q == SRC_INIT) begin
               wr_register_d = tbl_reg;
               wr_data_d     = tbl_data;
            end
            to_cnt_d = '0;
            state_d  = S_WAIT_DONE;
         end

         S_WAIT_DONE: begin
            if (wr_done) begin
               gap_cnt_d  = '0;
               host_ack_d = (src_q == SRC_HOST);
               state_d    = S_GAP;
            end else if (to_cnt_q >= TO_LAST) begin
               timeout_err_d = 1'b1;
               host_ack_d    = (src_q == SRC_HOST);
               state_d       = S_IDLE;
            end else begin
               to_cnt_d = sat_inc32(to_cnt_q);
            end
         end

         S_GAP: begin
            if (gap_cnt_q >= GAP_LAST) begin
               if (src_q == SRC_HOST) begin
                  state_d = S_IDLE;
               end else if (tbl_index_q == LAST_IDX) begin
                  init_done_d = 1'b1;
                  state_d     = S_IDLE;
               end else begin
                  tbl_index_d = tbl_index_q + IDX_W'(1);
                  state_d     = S_LOAD;
               end
            end else begin
               gap_cnt_d = sat_inc16(gap_cnt_q);
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Output decode. During an init ISSUE cycle the table fields are passed
   // straight through so the strobe and its payload leave together; the
   // captured copy holds them from then until wr_done.
   always_comb begin
      wr_addr     = CODEC_ADDR;
      wr_write    = (state_q == S_ISSUE);
      busy        = (state_q != S_IDLE);
      tbl_index   = tbl_index_q;
      host_ack    = host_ack_q;
      init_done   = init_done_q;
      timeout_err = timeout_err_q;
      if ((state_q == S_ISSUE) && (src_q == SRC_INIT)) begin
         wr_register = tbl_reg;
         wr_data     = tbl_data;
      end else begin
         wr_register = wr_register_q;
         wr_data     = wr_data_q;
      end
   end

endmodule
